// File: rtl/cr_prefix_tlv_chk.sv
// TLV framing checker with a 2-entry skid buffer, placed after prefix attach.
// Beats pass through unmodified; framing errors are pulsed, counted and latched into a sticky interrupt.
package cr_prefix_tlv_chk_pkg;

    typedef struct packed {
        logic        tvalid;
        logic        tlast;
        logic [7:0]  tkeep;
        logic [3:0]  tuser;
        logic [63:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

endpackage

module cr_prefix_tlv_chk
    import cr_prefix_tlv_chk_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  axi4s_dp_bus_t tlv_chk_ib_in,
    output axi4s_dp_rdy_t tlv_chk_ib_out,
    output axi4s_dp_bus_t tlv_chk_ob_out,
    input  axi4s_dp_rdy_t tlv_chk_ob_in,
    input  logic          clr_cnt,
    output logic          tlv_chk_err,
    output logic [2:0]    tlv_chk_err_code,
    output logic          tlv_chk_int,
    output logic [CNT_W-1:0] tlv_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BODY   = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_NO_SOT      = 3'd1;
    localparam logic [2:0] ERR_LEN_ZERO    = 3'd2;
    localparam logic [2:0] ERR_EARLY_EOT   = 3'd3;
    localparam logic [2:0] ERR_MISSING_EOT = 3'd4;
    localparam logic [2:0] ERR_SOT_IN_BODY = 3'd5;
    localparam logic [2:0] ERR_TLAST       = 3'd6;

    // Skid buffer: A drives the output, B catches the beat accepted while A stalls.
    axi4s_dp_bus_t r_aBeat;
    axi4s_dp_bus_t r_bBeat;
    logic          r_aValid;
    logic          r_bValid;
    logic          r_ready;

    logic w_acc;
    logic w_pop;
    logic w_aFree;
    logic w_bLoad;
    logic w_bValidNext;

    assign w_acc        = tlv_chk_ib_in.tvalid & r_ready;
    assign w_pop        = r_aValid & tlv_chk_ob_in.tready;
    assign w_aFree      = ~r_aValid | w_pop;
    assign w_bLoad      = w_acc & ~w_aFree;
    assign w_bValidNext = r_bValid ? ~w_aFree : w_bLoad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aBeat  <= '0;
            r_bBeat  <= '0;
            r_aValid <= 1'b0;
            r_bValid <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_ready  <= ~w_bValidNext;
            r_bValid <= w_bValidNext;
            if (w_aFree) begin
                r_aValid <= r_bValid | w_acc;
                r_aBeat  <= r_bValid ? r_bBeat : tlv_chk_ib_in;
            end
            if (w_bLoad) begin
                r_bBeat <= tlv_chk_ib_in;
            end
        end
    end

    always_comb begin
        tlv_chk_ob_out        = r_aBeat;
        tlv_chk_ob_out.tvalid = r_aValid;
        tlv_chk_ib_out.tready = r_ready;
    end

    // Framing checker runs on the accepted input beat, not on the buffered copy.
    state_t      r_state;
    state_t      w_stateNext;
    logic [15:0] r_wcnt;
    logic [15:0] r_len;
    logic [15:0] w_wcntNext;
    logic [15:0] w_lenNext;
    logic [15:0] w_cnt1;
    logic [15:0] w_len;
    logic        w_sot;
    logic        w_eot;
    logic        w_hdrEval;
    logic        w_frameErr;
    logic [2:0]  w_frameCode;
    logic        w_done;
    logic        w_lastErr;
    logic        w_err;
    logic [2:0]  w_errCode;
    logic        w_doneOk;

    assign w_sot  = tlv_chk_ib_in.tuser[0];
    assign w_eot  = tlv_chk_ib_in.tuser[1];
    assign w_len  = tlv_chk_ib_in.tdata[23:8];
    assign w_cnt1 = r_wcnt + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_wcnt  <= w_wcntNext;
            r_len   <= w_lenNext;
        end
    end

    // A SoT inside a body reports code 5 and is then treated as a fresh header.
    always_comb begin
        w_stateNext = r_state;
        w_wcntNext  = r_wcnt;
        w_lenNext   = r_len;
        w_hdrEval   = 1'b0;
        w_frameErr  = 1'b0;
        w_frameCode = ERR_NONE;
        w_done      = 1'b0;
        if (w_acc) begin
            case (r_state)
                ST_IDLE: begin
                    w_hdrEval = 1'b1;
                end
                ST_BODY: begin
                    if (w_sot) begin
                        w_frameErr  = 1'b1;
                        w_frameCode = ERR_SOT_IN_BODY;
                        w_hdrEval   = 1'b1;
                    end else if (w_eot) begin
                        w_stateNext = ST_IDLE;
                        w_wcntNext  = '0;
                        if (w_cnt1 == r_len) begin
                            w_done = 1'b1;
                        end else begin
                            w_frameErr  = 1'b1;
                            w_frameCode = ERR_EARLY_EOT;
                        end
                    end else if (w_cnt1 == r_len) begin
                        w_frameErr  = 1'b1;
                        w_frameCode = ERR_MISSING_EOT;
                        w_stateNext = ST_RESYNC;
                        w_wcntNext  = '0;
                    end else begin
                        w_wcntNext = w_cnt1;
                    end
                end
                ST_RESYNC: begin
                    w_hdrEval = w_sot;
                end
                default: begin
                    w_stateNext = ST_IDLE;
                end
            endcase

            if (w_hdrEval) begin
                w_wcntNext = '0;
                w_lenNext  = w_len;
                if (!w_sot) begin
                    w_frameErr  = 1'b1;
                    w_frameCode = ERR_NO_SOT;
                    w_stateNext = ST_RESYNC;
                end else if (w_len == 16'd0) begin
                    w_frameErr  = 1'b1;
                    if (w_frameCode == ERR_NONE) w_frameCode = ERR_LEN_ZERO;
                    w_stateNext = ST_RESYNC;
                end else if (w_eot) begin
                    w_stateNext = ST_IDLE;
                    if (w_len == 16'd1) begin
                        w_done = ~w_frameErr;
                    end else begin
                        w_frameErr = 1'b1;
                        if (w_frameCode == ERR_NONE) w_frameCode = ERR_EARLY_EOT;
                    end
                end else if (w_len == 16'd1) begin
                    w_frameErr  = 1'b1;
                    if (w_frameCode == ERR_NONE) w_frameCode = ERR_MISSING_EOT;
                    w_stateNext = ST_RESYNC;
                end else begin
                    w_wcntNext  = 16'd1;
                    w_stateNext = ST_BODY;
                end
            end
        end
    end

    // tlast disagreeing with EoT overrides the reported code but not the FSM path.
    assign w_lastErr = w_acc & (tlv_chk_ib_in.tlast != w_eot);
    assign w_err     = w_frameErr | w_lastErr;
    assign w_errCode = w_lastErr ? ERR_TLAST : w_frameCode;
    assign w_doneOk  = w_done & ~w_err;

    logic             r_err;
    logic [2:0]       r_errCode;
    logic             r_int;
    logic [CNT_W-1:0] r_tlvCnt;
    logic [CNT_W-1:0] r_errCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_errCode <= ERR_NONE;
            r_int     <= 1'b0;
            r_tlvCnt  <= '0;
            r_errCnt  <= '0;
        end else begin
            r_err     <= w_err;
            r_errCode <= w_err ? w_errCode : ERR_NONE;
            if (clr_cnt) begin
                r_int    <= 1'b0;
                r_tlvCnt <= '0;
                r_errCnt <= '0;
            end else begin
                if (w_err) r_int <= 1'b1;
                if (w_doneOk && (r_tlvCnt != '1)) r_tlvCnt <= r_tlvCnt + CNT_W'(1);
                if (w_err && (r_errCnt != '1)) r_errCnt <= r_errCnt + CNT_W'(1);
            end
        end
    end

    assign tlv_chk_err      = r_err;
    assign tlv_chk_err_code = r_errCode;
    assign tlv_chk_int      = r_int;
    assign tlv_cnt          = r_tlvCnt;
    assign err_cnt          = r_errCnt;

endmodule

// File: tb/tb_cr_prefix_tlv_chk.sv
// Directed bench for cr_prefix_tlv_chk: scoreboarded pass-through, ready model and framing error checks.
// Uses a 4-bit counter width so saturation is reachable in a few dozen beats.
module tb_cr_prefix_tlv_chk;
    import cr_prefix_tlv_chk_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    axi4s_dp_bus_t    ibIn;
    axi4s_dp_rdy_t    ibRdy;
    axi4s_dp_bus_t    obOut;
    axi4s_dp_rdy_t    obRdy;
    logic             clrCnt;
    logic             err;
    logic [2:0]       errCode;
    logic             intFlag;
    logic [CNT_W-1:0] tlvCnt;
    logic [CNT_W-1:0] errCnt;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int accCnt = 0;
    int popCnt = 0;
    bit chkLatency = 1'b0;
    bit chkReady = 1'b0;
    bit streamDone = 1'b0;

    axi4s_dp_bus_t expQ[$];
    int            expCyc[$];
    logic [2:0]    errQ[$];

    cr_prefix_tlv_chk #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tlv_chk_ib_in    (ibIn),
        .tlv_chk_ib_out   (ibRdy),
        .tlv_chk_ob_out   (obOut),
        .tlv_chk_ob_in    (obRdy),
        .clr_cnt          (clrCnt),
        .tlv_chk_err      (err),
        .tlv_chk_err_code (errCode),
        .tlv_chk_int      (intFlag),
        .tlv_cnt          (tlvCnt),
        .err_cnt          (errCnt)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cycleCnt = cycleCnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output scoreboard, tready occupancy model and error-pulse recorder, all sampled on the falling edge.
    initial begin
        axi4s_dp_bus_t e;
        int c;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (chkReady) checkOutput("ib_tready", ibRdy.tready, ((accCnt - popCnt) < 2));
                if (obOut.tvalid && obRdy.tready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("ob_extra_beat", expQ.size(), 1);
                    end else begin
                        e = expQ.pop_front();
                        c = expCyc.pop_front();
                        checkOutput("ob_beat", obOut, e);
                        if (chkLatency) checkOutput("ob_latency", cycleCnt, c);
                    end
                    popCnt++;
                end
                if (err) errQ.push_back(errCode);
            end
        end
    end

    function automatic axi4s_dp_bus_t mkBeat(input bit sot, input bit eot, input bit last,
                                             input logic [15:0] len, input logic [31:0] tag);
        axi4s_dp_bus_t b;
        b        = '0;
        b.tvalid = 1'b1;
        b.tlast  = last;
        b.tkeep  = 8'hFF;
        b.tuser  = {2'b00, eot, sot};
        b.tdata  = {tag, 8'h3C, len, 8'h5A};
        return b;
    endfunction

    // Presents one beat and holds it until accepted; called and returns at posedge+1.
    task automatic applyStimulus(input axi4s_dp_bus_t b);
        bit acc;
        acc = 1'b0;
        ibIn = b;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = ibRdy.tready;
            @(posedge clk);
        end
        #1;
        ibIn.tvalid = 1'b0;
        if (acc) begin
            expQ.push_back(b);
            expCyc.push_back(cycleCnt);
            accCnt++;
        end else begin
            checkOutput("ib_accept_timeout", acc, 1);
        end
    endtask

    task automatic sendTlv(input int len, input logic [31:0] base, input int maxGap);
        for (int i = 0; i < len; i++) begin
            if (maxGap > 0) begin
                repeat ($urandom_range(0, maxGap)) begin
                    @(posedge clk);
                    #1;
                end
            end
            applyStimulus(mkBeat(i == 0, i == len - 1, i == len - 1,
                                 (i == 0) ? 16'(len) : 16'hBEEF, base + 32'(i)));
        end
    endtask

    task automatic waitDrain();
        obRdy.tready = 1'b1;
        for (int i = 0; i < 300 && expQ.size() != 0; i++) @(posedge clk);
        checkOutput("drain", expQ.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clearCounters();
        clrCnt = 1'b1;
        @(posedge clk);
        #1;
        clrCnt = 1'b0;
        errQ.delete();
        checkOutput("clr_tlv_cnt", tlvCnt, 0);
        checkOutput("clr_err_cnt", errCnt, 0);
        checkOutput("clr_int", intFlag, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        chkReady = 1'b0;
        ibIn = '0;
        obRdy.tready = 1'b1;
        clrCnt = 1'b0;
        expQ.delete();
        expCyc.delete();
        errQ.delete();
        accCnt = 0;
        popCnt = 0;
        #1;
        checkOutput("rst_ob_tvalid", obOut.tvalid, 0);
        checkOutput("rst_ib_tready", ibRdy.tready, 0);
        checkOutput("rst_err", {err, errCode}, 0);
        checkOutput("rst_counters", {intFlag, tlvCnt, errCnt}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_tready", ibRdy.tready, 1);
        chkReady = 1'b1;
    endtask

    task automatic checkErrs(input string tag, input int n, input logic [2:0] code);
        checkOutput({tag, "_err_pulses"}, errQ.size(), n);
        foreach (errQ[i]) checkOutput({tag, "_err_code"}, errQ[i], code);
    endtask

    initial begin
        ibIn = '0;
        obRdy.tready = 1'b1;
        clrCnt = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] test 1: back-to-back TLVs len 1,4,2");
        chkLatency = 1'b1;
        sendTlv(1, 32'h1000, 0);
        sendTlv(4, 32'h2000, 0);
        sendTlv(2, 32'h3000, 0);
        waitDrain();
        chkLatency = 1'b0;
        checkOutput("t1_tlv_cnt", tlvCnt, 3);
        checkOutput("t1_err_cnt", errCnt, 0);
        checkOutput("t1_int", intFlag, 0);
        checkErrs("t1", 0, 3'd0);

        $display("[TB] test 2: same stream, toggling ob tready and input gaps");
        clearCounters();
        streamDone = 1'b0;
        fork
            begin
                sendTlv(1, 32'h1000, 2);
                sendTlv(4, 32'h2000, 2);
                sendTlv(2, 32'h3000, 2);
                streamDone = 1'b1;
            end
            begin
                while (!streamDone) begin
                    @(posedge clk);
                    #1;
                    obRdy.tready = ~obRdy.tready;
                end
            end
        join
        waitDrain();
        checkOutput("t2_tlv_cnt", tlvCnt, 3);
        checkOutput("t2_err_cnt", errCnt, 0);
        checkErrs("t2", 0, 3'd0);

        $display("[TB] test 3: len 4 with EoT on beat 3, then good len 2");
        clearCounters();
        applyStimulus(mkBeat(1, 0, 0, 16'd4, 32'h4000));
        applyStimulus(mkBeat(0, 0, 0, 16'hBEEF, 32'h4001));
        applyStimulus(mkBeat(0, 1, 1, 16'hBEEF, 32'h4002));
        sendTlv(2, 32'h4100, 0);
        waitDrain();
        checkErrs("t3", 1, 3'd3);
        checkOutput("t3_err_cnt", errCnt, 1);
        checkOutput("t3_int", intFlag, 1);
        checkOutput("t3_tlv_cnt", tlvCnt, 1);

        $display("[TB] test 4: SoT at beat 2 of len 5, new len 2 TLV");
        clearCounters();
        applyStimulus(mkBeat(1, 0, 0, 16'd5, 32'h5000));
        applyStimulus(mkBeat(1, 0, 0, 16'd2, 32'h5100));
        applyStimulus(mkBeat(0, 1, 1, 16'hBEEF, 32'h5101));
        waitDrain();
        checkErrs("t4", 1, 3'd5);
        checkOutput("t4_tlv_cnt", tlvCnt, 1);
        checkOutput("t4_err_cnt", errCnt, 1);

        $display("[TB] test 5: reset mid-TLV, then no-SoT beat, junk, good len 1");
        obRdy.tready = 1'b0;
        applyStimulus(mkBeat(1, 0, 0, 16'd4, 32'h6000));
        applyStimulus(mkBeat(0, 0, 0, 16'hBEEF, 32'h6001));
        checkOutput("t5_held_tvalid", obOut.tvalid, 1);
        doReset();
        applyStimulus(mkBeat(0, 0, 0, 16'd3, 32'h7000));
        for (int i = 1; i <= 3; i++) applyStimulus(mkBeat(0, 0, 0, 16'hBEEF, 32'h7000 + 32'(i)));
        sendTlv(1, 32'h7100, 0);
        waitDrain();
        checkErrs("t5", 1, 3'd1);
        checkOutput("t5_tlv_cnt", tlvCnt, 1);
        checkOutput("t5_err_cnt", errCnt, 1);
        checkOutput("t5_beats_out", popCnt, 5);

        $display("[TB] test 6: err_cnt saturation and clear with simultaneous error");
        clearCounters();
        for (int i = 0; i < 20; i++) applyStimulus(mkBeat(0, 0, 1, 16'hBEEF, 32'h8000 + 32'(i)));
        waitDrain();
        checkErrs("t6", 20, 3'd6);
        checkOutput("t6_err_cnt_sat", errCnt, 15);
        checkOutput("t6_int", intFlag, 1);
        clrCnt = 1'b1;
        applyStimulus(mkBeat(0, 0, 1, 16'hBEEF, 32'h8100));
        clrCnt = 1'b0;
        checkOutput("t6_clr_err_pulse", {err, errCode}, {1'b1, 3'd6});
        checkOutput("t6_clr_err_cnt", errCnt, 0);
        checkOutput("t6_clr_int", intFlag, 0);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
